// File: rtl/vga_image_scanner_pkg.sv
// Shared timing defaults, region tag and sync/blank bundle for the VGA image scanner.
// No storage here; latency and backpressure are properties of the modules that import it.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int IMG_W    = 256;
  localparam int IMG_H    = 256;
  localparam int ENC_X0   = 32;
  localparam int DEC_X0   = 352;
  localparam int IMG_Y0   = 112;
  localparam int RD_LAT   = 1;
  localparam logic [7:0] BG_COLOR = 8'h20;

  // Wide enough for both counters at the default timing (800 x 525).
  localparam int CNT_W = 11;

  typedef enum logic [1:0] {REG_BG, REG_ENC, REG_DEC} region_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic frame_start;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/vga_image_scanner_if.sv
// Memory read port plus VGA output bundle; master is the scanner, slave is memory/display side.
// Pure wiring: no latency, no backpressure.
interface vga_image_scanner_if;
  logic [7:0]  encrypted_gpu;
  logic [7:0]  decrypted_gpu;
  logic [31:0] gpu_address;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic        sync_n;
  logic        frame_start;

  modport master (
    input  encrypted_gpu, decrypted_gpu,
    output gpu_address, vga_r, vga_g, vga_b, hsync, vsync, blank_n, sync_n, frame_start
  );

  modport slave (
    output encrypted_gpu, decrypted_gpu,
    input  gpu_address, vga_r, vga_g, vga_b, hsync, vsync, blank_n, sync_n, frame_start
  );
endinterface

// File: rtl/vga_image_scanner_timing.sv
// Free-running h/v raster counters with raw (undelayed) sync/blank/frame decode.
// Decode is combinational on the counter registers; no backpressure.
module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [vga_pkg::CNT_W-1:0]   o_h,
  output logic [vga_pkg::CNT_W-1:0]   o_v,
  output vga_pkg::ctl_t               o_ctl
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HA    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_MAX) begin
      r_h <= '0;
      r_v <= (r_v == V_MAX) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  always_comb begin
    o_ctl             = CTL_RST;
    o_ctl.hsync       = !((r_h >= HS_LO) && (r_h < HS_HI));
    o_ctl.vsync       = !((r_v >= VS_LO) && (r_v < VS_HI));
    o_ctl.blank_n     = (r_h < HA) && (r_v < VA);
    o_ctl.frame_start = (r_h == '0) && (r_v == '0);
  end

  assign o_h = r_h;
  assign o_v = r_v;

endmodule

// File: rtl/vga_image_scanner.sv
// Side-by-side encrypted/decrypted image scanner: address one cycle after (h,v), pixel and syncs
// RD_LAT+2 cycles after (h,v). No backpressure; memory data is sampled blindly at RD_LAT.
module vga_image_scanner #(
  parameter int         H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int         H_FP     = vga_pkg::H_FP,
  parameter int         H_SYNC   = vga_pkg::H_SYNC,
  parameter int         H_BP     = vga_pkg::H_BP,
  parameter int         V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int         V_FP     = vga_pkg::V_FP,
  parameter int         V_SYNC   = vga_pkg::V_SYNC,
  parameter int         V_BP     = vga_pkg::V_BP,
  parameter int         IMG_W    = vga_pkg::IMG_W,
  parameter int         IMG_H    = vga_pkg::IMG_H,
  parameter int         ENC_X0   = vga_pkg::ENC_X0,
  parameter int         DEC_X0   = vga_pkg::DEC_X0,
  parameter int         IMG_Y0   = vga_pkg::IMG_Y0,
  parameter int         RD_LAT   = vga_pkg::RD_LAT,
  parameter logic [7:0] BG_COLOR = vga_pkg::BG_COLOR
) (
  input  logic                clk,
  input  logic                reset,
  vga_image_scanner_if.master vga_bus
);
  import vga_pkg::*;

  if ((IMG_W & (IMG_W - 1)) != 0) begin : g_bad_img_w
    $error("IMG_W must be a power of two");
  end
  if ((ENC_X0 + IMG_W > DEC_X0) && (DEC_X0 + IMG_W > ENC_X0)) begin : g_overlap
    $error("encrypted and decrypted windows overlap");
  end
  if ((ENC_X0 + IMG_W > H_ACTIVE) || (DEC_X0 + IMG_W > H_ACTIVE) ||
      (IMG_Y0 + IMG_H > V_ACTIVE)) begin : g_outside
    $error("image window leaves the active area");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("RD_LAT must be at least 1");
  end

  localparam int IMG_SHIFT = $clog2(IMG_W);
  localparam logic [CNT_W-1:0] EX0 = CNT_W'(ENC_X0);
  localparam logic [CNT_W-1:0] EX1 = CNT_W'(ENC_X0 + IMG_W);
  localparam logic [CNT_W-1:0] DX0 = CNT_W'(DEC_X0);
  localparam logic [CNT_W-1:0] DX1 = CNT_W'(DEC_X0 + IMG_W);
  localparam logic [CNT_W-1:0] Y0  = CNT_W'(IMG_Y0);
  localparam logic [CNT_W-1:0] Y1  = CNT_W'(IMG_Y0 + IMG_H);

  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  ctl_t             w_ctl;
  region_t          w_tag;
  logic [CNT_W-1:0] w_x_off;
  logic [CNT_W-1:0] w_y_off;
  logic [31:0]      w_addr;

  logic [31:0]      r_addr;
  region_t          r_tag [RD_LAT+1];
  ctl_t             r_ctl [RD_LAT+2];
  logic [7:0]       r_pix;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk   (clk),
    .reset (reset),
    .o_h   (w_h),
    .o_v   (w_v),
    .o_ctl (w_ctl)
  );

  always_comb begin
    w_tag   = REG_BG;
    w_x_off = '0;
    w_y_off = w_v - Y0;
    w_addr  = '0;
    if ((w_v >= Y0) && (w_v < Y1)) begin
      if ((w_h >= EX0) && (w_h < EX1)) begin
        w_tag   = REG_ENC;
        w_x_off = w_h - EX0;
      end else if ((w_h >= DX0) && (w_h < DX1)) begin
        w_tag   = REG_DEC;
        w_x_off = w_h - DX0;
      end
    end
    if (w_tag != REG_BG) begin
      w_addr = (32'(w_y_off) << IMG_SHIFT) | 32'(w_x_off);
    end
  end

  // Tag waits RD_LAT+1 stages so it meets the memory data; ctl waits one more to meet r_pix.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_pix  <= '0;
      for (int i = 0; i < RD_LAT + 1; i++) r_tag[i] <= REG_BG;
      for (int i = 0; i < RD_LAT + 2; i++) r_ctl[i] <= CTL_RST;
    end else begin
      r_addr   <= w_addr;
      r_tag[0] <= w_tag;
      r_ctl[0] <= w_ctl;
      for (int i = 1; i < RD_LAT + 1; i++) r_tag[i] <= r_tag[i-1];
      for (int i = 1; i < RD_LAT + 2; i++) r_ctl[i] <= r_ctl[i-1];
      if (!r_ctl[RD_LAT].blank_n) begin
        r_pix <= '0;
      end else begin
        case (r_tag[RD_LAT])
          REG_ENC: r_pix <= vga_bus.encrypted_gpu;
          REG_DEC: r_pix <= vga_bus.decrypted_gpu;
          default: r_pix <= BG_COLOR;
        endcase
      end
    end
  end

  assign vga_bus.gpu_address = r_addr;
  assign vga_bus.vga_r       = r_pix;
  assign vga_bus.vga_g       = r_pix;
  assign vga_bus.vga_b       = r_pix;
  assign vga_bus.hsync       = r_ctl[RD_LAT+1].hsync;
  assign vga_bus.vsync       = r_ctl[RD_LAT+1].vsync;
  assign vga_bus.blank_n     = r_ctl[RD_LAT+1].blank_n;
  assign vga_bus.frame_start = r_ctl[RD_LAT+1].frame_start;
  assign vga_bus.sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner with the default horizontal timing and a shortened vertical
// raster so a whole frame fits; memories return addr[7:0] (ENC) and ~addr[7:0] (DEC).
module tb_vga_image_scanner;

  localparam int RD_LAT = 1;
  localparam int LAT    = RD_LAT + 2;
  localparam int HT     = 640 + 16 + 96 + 48;
  localparam int VA     = 32;
  localparam int VFP    = 2;
  localparam int VSY    = 2;
  localparam int VBP    = 3;
  localparam int VT     = VA + VFP + VSY + VBP;
  localparam int FRAME  = HT * VT;
  localparam int IW     = 256;
  localparam int IH     = 16;
  localparam int EX0    = 32;
  localparam int DX0    = 352;
  localparam int IY0    = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  vga_image_scanner_if bus();

  vga_image_scanner #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .IMG_H(IH), .IMG_Y0(IY0), .RD_LAT(RD_LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .vga_bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: fixed read latency of RD_LAT cycles from gpu_address.
  logic [31:0] mem_q [RD_LAT];
  always @(posedge clk) begin
    mem_q[0] <= bus.gpu_address;
    for (int i = 1; i < RD_LAT; i++) mem_q[i] <= mem_q[i-1];
  end
  assign bus.encrypted_gpu = mem_q[RD_LAT-1][7:0];
  assign bus.decrypted_gpu = ~mem_q[RD_LAT-1][7:0];

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        sn;
    logic        fs;
  } obs_t;

  typedef struct {
    bit          pix;
    int          v;
    int          h;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];
  int   total = 0;
  int   bad   = 0;
  int   k     = -1;  // rising edges without reset since the last reset edge

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic bit in_rows(int v);
    return (v >= IY0) && (v < IY0 + IH);
  endfunction

  function automatic bit in_enc(int h, int v);
    return in_rows(v) && (h >= EX0) && (h < EX0 + IW);
  endfunction

  function automatic bit in_dec(int h, int v);
    return in_rows(v) && (h >= DX0) && (h < DX0 + IW);
  endfunction

  function automatic logic [31:0] win_addr(int h, int v);
    if (in_enc(h, v)) return 32'((v - IY0) * IW + (h - EX0));
    if (in_dec(h, v)) return 32'((v - IY0) * IW + (h - DX0));
    return 32'd0;
  endfunction

  function automatic logic [7:0] pix_at(int h, int v);
    logic [31:0] a;
    a = win_addr(h, v);
    if (in_enc(h, v)) return a[7:0];
    if (in_dec(h, v)) return ~a[7:0];
    return 8'h20;
  endfunction

  // Expected outputs after kk clean edges: address shows raster position kk-1, pixel kk-LAT.
  function automatic obs_t model(int kk);
    obs_t o;
    int p, h, v;
    o = '{addr: 32'd0, r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b1, vs: 1'b1, bl: 1'b0, sn: 1'b0, fs: 1'b0};
    if (kk >= 1) begin
      p = kk - 1;
      h = p % HT;
      v = (p / HT) % VT;
      o.addr = win_addr(h, v);
    end
    if (kk >= LAT) begin
      p = kk - LAT;
      h = p % HT;
      v = (p / HT) % VT;
      o.bl = (h < 640) && (v < VA);
      o.hs = !((h >= 656) && (h < 752));
      o.vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
      o.fs = (p % FRAME) == 0;
      if (o.bl) begin
        o.r = pix_at(h, v);
        o.g = o.r;
        o.b = o.r;
      end
    end
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.addr = bus.gpu_address;
    o.r    = bus.vga_r;
    o.g    = bus.vga_g;
    o.b    = bus.vga_b;
    o.hs   = bus.hsync;
    o.vs   = bus.vsync;
    o.bl   = bus.blank_n;
    o.sn   = bus.sync_n;
    o.fs   = bus.frame_start;
    return o;
  endfunction

  task automatic tick();
    obs_t got, exp;
    @(posedge clk);
    if (reset) k = 0;
    else if (k >= 0) k++;
    #1;
    if (k >= 0) begin
      got = observe();
      exp = model(k);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL model k=%0d: got %h, expected %h", k, got, exp);
      end
    end
  endtask

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 40000) begin
      tick();
      guard++;
    end
    if (k != target) begin
      total++;
      bad++;
      $display("FAIL wait_k: reached k=%0d, required %0d", k, target);
    end
  endtask

  function automatic bit active(int sel);
    if (sel == 0) return !bus.hsync;
    if (sel == 1) return !bus.vsync;
    return bus.blank_n;
  endfunction

  // Finds the first active run at or after from_k and returns its start edge and length.
  task automatic measure(input int sel, input int from_k, input int max_cyc,
                         output int start_k, output int len);
    int guard;
    wait_k(from_k);
    start_k = -1;
    len     = 0;
    guard   = 0;
    while (guard < max_cyc) begin
      if (active(sel)) begin
        if (start_k < 0) start_k = k;
        len++;
      end else if (start_k >= 0) begin
        break;
      end
      tick();
      guard++;
    end
  endtask

  function automatic void add(bit pix, int v, int h, logic [31:0] e);
    tbl.push_back('{pix, v, h, e});
  endfunction

  task automatic wait_fs(input int max_cyc);
    int guard;
    guard = 0;
    while (bus.frame_start !== 1'b1 && guard < max_cyc) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    int s, l, target, first_fs;

    // Entries are in raster order of the edge at which they become visible.
    add(1, 0,   0,   32'h20);
    add(0, 7,   100, 32'h0);   add(1, 7,   100, 32'h20);
    add(1, 8,   0,   32'h20);
    add(0, 8,   32,  32'h0);   add(1, 8,   32,  32'h00);
    add(0, 8,   287, 32'hFF);  add(0, 8,   288, 32'h0);
    add(1, 8,   287, 32'hFF);  add(1, 8,   288, 32'h20);
    add(0, 8,   352, 32'h0);   add(1, 8,   352, 32'hFF);
    add(0, 9,   31,  32'h0);   add(1, 9,   31,  32'h20);
    add(0, 9,   352, 32'd256); add(1, 9,   352, 32'hFF);
    add(0, 9,   607, 32'd511); add(0, 9,   608, 32'h0);
    add(1, 9,   607, 32'h00);  add(1, 9,   608, 32'h20);
    add(1, 9,   640, 32'h00);
    add(0, 23,  32,  32'hF00); add(1, 23,  32,  32'h00);
    add(0, 23,  287, 32'hFFF); add(1, 23,  287, 32'hFF);
    add(0, 24,  32,  32'h0);   add(1, 24,  32,  32'h20);

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_vga_r",   64'(bus.vga_r),       64'h0);
    chk("rst_hsync",   64'(bus.hsync),       64'h1);
    chk("rst_vsync",   64'(bus.vsync),       64'h1);
    chk("rst_blank_n", 64'(bus.blank_n),     64'h0);
    chk("rst_addr",    64'(bus.gpu_address), 64'h0);
    chk("rst_fs",      64'(bus.frame_start), 64'h0);

    reset = 1'b0;
    wait_fs(20);
    first_fs = k;
    chk("first_fs_edge", 64'(k), 64'(LAT));
    chk("first_fs_pix",  64'(bus.vga_r), 64'h20);

    foreach (tbl[i]) begin
      target = tbl[i].v * HT + tbl[i].h + (tbl[i].pix ? LAT : 1);
      wait_k(target);
      if (tbl[i].pix)
        chk($sformatf("pix v=%0d h=%0d", tbl[i].v, tbl[i].h), 64'(bus.vga_r), 64'(tbl[i].exp[7:0]));
      else
        chk($sformatf("addr v=%0d h=%0d", tbl[i].v, tbl[i].h), 64'(bus.gpu_address), 64'(tbl[i].exp));
    end

    measure(0, 25 * HT + LAT, 900, s, l);
    chk("hsync_start", 64'(s), 64'(25 * HT + 656 + LAT));
    chk("hsync_len",   64'(l), 64'd96);
    measure(2, 27 * HT - 100, 900, s, l);
    chk("blank_start", 64'(s), 64'(27 * HT + LAT));
    chk("blank_len",   64'(l), 64'd640);
    measure(1, 32 * HT, 4000, s, l);
    chk("vsync_start", 64'(s), 64'((VA + VFP) * HT + LAT));
    chk("vsync_len",   64'(l), 64'(VSY * HT));

    wait_k(FRAME - 200);
    wait_fs(400);
    chk("fs_period", 64'(k - first_fs), 64'(FRAME));

    // One-cycle reset in the middle of an image line of the second frame.
    wait_k(FRAME + 10 * HT + 123);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_vga_r", 64'(bus.vga_r),       64'h0);
    chk("mid_rst_addr",  64'(bus.gpu_address), 64'h0);
    chk("mid_rst_blank", 64'(bus.blank_n),     64'h0);
    chk("mid_rst_hsync", 64'(bus.hsync),       64'h1);
    wait_fs(20);
    chk("restart_fs_edge", 64'(k), 64'(LAT));

    for (int n = 0; n < 6; n++) begin
      repeat ((n % 2 == 0) ? $urandom_range(8000, 4000) : $urandom_range(200, 5)) tick();
      reset = 1'b1;
      repeat ($urandom_range(3, 1)) tick();
      reset = 1'b0;
    end
    repeat (1000) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
